// File: rtl/cpu_step_clk.sv
// cpu_step_clk: turns a bouncing step button into one clean CPU clock pulse per
// press, or free-runs the CPU clock at a fixed period when run_en is set.
// Also counts clk_cpu rising edges for a debug display.
module cpu_step_clk #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int PULSE_CYCLES    = 16,
    parameter int RUN_PERIOD      = 50_000_000,
    parameter int CNT_W           = 16
) (
    input  logic             clk_100m,
    input  logic             reset,
    input  logic             btn_step,
    input  logic             run_en,
    output logic             clk_cpu,
    output logic             busy,
    output logic [CNT_W-1:0] step_cnt
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TM_W = $clog2(RUN_PERIOD + 1);

    localparam logic [DB_W-1:0] DB_LAST       = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] HIGH_LAST     = TM_W'(PULSE_CYCLES - 1);
    localparam logic [TM_W-1:0] LOW_STEP_LAST = TM_W'(PULSE_CYCLES - 1);
    localparam logic [TM_W-1:0] LOW_RUN_LAST  = TM_W'(RUN_PERIOD - PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Two-flop synchronizers for the raw button and switch
    logic btn_meta_q, btn_meta_d;
    logic btn_sync_q, btn_sync_d;
    logic run_meta_q, run_meta_d;
    logic run_sync_q, run_sync_d;

    // Debounce state and the press strobe
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            db_lvl_q, db_lvl_d;
    logic            step_req_q, step_req_d;

    // Pulse generator state
    state_t             state_q, state_d;
    logic [TM_W-1:0]    timer_q, timer_d;
    logic [TM_W-1:0]    low_last_q, low_last_d;
    logic               clk_cpu_q, clk_cpu_d;
    logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;

    // Synchronizer shift: each stage simply takes the previous one
    always_comb begin
        btn_meta_d = btn_step;
        btn_sync_d = btn_meta_q;
        run_meta_d = run_en;
        run_sync_d = run_meta_q;
    end

    // Debounce: accept a new level only after it differs for DEBOUNCE_CYCLES cycles;
    // the strobe fires only on an accepted press, never on release
    always_comb begin
        db_cnt_d   = '0;
        db_lvl_d   = db_lvl_q;
        step_req_d = 1'b0;
        if (btn_sync_q != db_lvl_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_lvl_d   = btn_sync_q;
                step_req_d = btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Pulse FSM: HIGH is always PULSE_CYCLES long; LOW length is fixed on entry so a
    // run_en change can never truncate or stretch a pulse already in flight
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        low_last_d = low_last_q;
        step_cnt_d = step_cnt_q;
        case (state_q)
            IDLE: begin
                if (run_sync_q || step_req_q) begin
                    state_d = HIGH;
                    timer_d = '0;
                end
            end
            HIGH: begin
                if (timer_q == HIGH_LAST) begin
                    state_d    = LOW;
                    timer_d    = '0;
                    low_last_d = run_sync_q ? LOW_RUN_LAST : LOW_STEP_LAST;
                end else begin
                    timer_d = timer_q + TM_W'(1);
                end
            end
            LOW: begin
                if (timer_q == low_last_q) begin
                    timer_d = '0;
                    state_d = run_sync_q ? HIGH : IDLE;
                end else begin
                    timer_d = timer_q + TM_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
        if ((state_q != HIGH) && (state_d == HIGH)) begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
        end
        // Registered so clk_cpu is glitch-free and high exactly while the FSM is in HIGH
        clk_cpu_d = (state_d == HIGH);
    end

    // All state registers; reset asynchronously forces clk_cpu low at once
    always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            run_meta_q <= 1'b0;
            run_sync_q <= 1'b0;
            db_cnt_q   <= '0;
            db_lvl_q   <= 1'b0;
            step_req_q <= 1'b0;
            state_q    <= IDLE;
            timer_q    <= '0;
            low_last_q <= '0;
            clk_cpu_q  <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            run_meta_q <= run_meta_d;
            run_sync_q <= run_sync_d;
            db_cnt_q   <= db_cnt_d;
            db_lvl_q   <= db_lvl_d;
            step_req_q <= step_req_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            low_last_q <= low_last_d;
            clk_cpu_q  <= clk_cpu_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign clk_cpu  = clk_cpu_q;
    assign busy     = (state_q != IDLE);
    assign step_cnt = step_cnt_q;

endmodule
